// File: rtl/mux_pkg.sv
// Shared constants for the word multiplexer and everything that drives it.
//
// Contents:
//   MUX_WIDTH_DEFAULT : default data word width (32)
//   CNT_W_DEFAULT     : default select-toggle counter width (16)
//   SEL_A0 / SEL_A1   : select encodings; callers drive s with these
//                       instead of bare 1'b0 / 1'b1.
package mux_pkg;

  localparam int MUX_WIDTH_DEFAULT = 32;
  localparam int CNT_W_DEFAULT     = 16;

  localparam logic SEL_A0 = 1'b0;
  localparam logic SEL_A1 = 1'b1;

endpackage : mux_pkg

// File: rtl/mux2_slice.sv
// Parameterised-width combinational 2:1 multiplexer.
//
// Ports:
//   a0 [WIDTH] : word chosen when s == SEL_A0
//   a1 [WIDTH] : word chosen when s == SEL_A1
//   s          : select
//   y  [WIDTH] : selected word, no clock dependence
//
// The conditional operator is used deliberately: when s is X/Z in
// simulation it merges a0 and a1 bitwise (agreeing bits keep their value,
// the rest go X), while synthesis still maps it to a plain mux.
module mux2_slice
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = (s == SEL_A1) ? a1 : a0;

endmodule : mux2_slice

// File: rtl/mux_32_2_1.sv
// Two-input word multiplexer with registered output/select copies and an
// optional select-toggle counter for debug.
//
// Configuration macro: MUX_32_2_1_STATS_EN
//   defined   -> tog_cnt port and saturating toggle counter compiled in
//   undefined -> tog_cnt port and counter absent; y, y_q, s_q unchanged
//
// Ports:
//   clk              : clock, all state updates on rising edge
//   rst              : synchronous reset, active-high
//   a0, a1 [WIDTH]   : data inputs
//   s                : select (SEL_A0 -> a0, SEL_A1 -> a1)
//   y      [WIDTH]   : combinational selected word, unaffected by rst
//   y_q    [WIDTH]   : y registered on the rising edge (0 in reset)
//   s_q              : s registered on the rising edge (0 in reset)
//   tog_cnt [CNT_W]  : stats builds only; count of edges where s != s_q
//
// Handshake: none. Inputs are sampled on every rising edge with no
// valid/ready qualification; they only need to be stable around the edge.
module mux_32_2_1
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic             s,
  output logic [WIDTH-1:0] y,
`ifdef MUX_32_2_1_STATS_EN
  output logic [CNT_W-1:0] tog_cnt,
`endif
  output logic [WIDTH-1:0] y_q,
  output logic             s_q
);

  // Combinational select path.
  mux2_slice #(
    .WIDTH (WIDTH)
  ) u_slice (
    .a0 (a0),
    .a1 (a1),
    .s  (s),
    .y  (y)
  );

  // Pipelined copies of the output word and the select.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
      s_q <= SEL_A0;
    end else begin
      y_q <= y;
      s_q <= s;
    end
  end

`ifdef MUX_32_2_1_STATS_EN
  // A toggle is any non-reset edge where the incoming select differs from
  // the registered one. Because s_q resets to 0, s = 1 on the first edge
  // after reset counts as a toggle. Reset takes priority, so a select
  // change on a reset edge is never counted.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic toggle;
  logic cnt_full;

  assign toggle   = (s != s_q);
  assign cnt_full = (tog_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      tog_cnt <= '0;
    end else if (toggle && !cnt_full) begin
      tog_cnt <= tog_cnt + 1'b1;
    end
  end
`endif

endmodule : mux_32_2_1

// File: tb/tb_mux_32_2_1.sv
// Self-checking bench for mux_32_2_1. Builds with or without
// MUX_32_2_1_STATS_EN; counter scenarios are compiled only in stats builds
// (where the DUT counter is narrowed to 4 bits to reach saturation).
module tb_mux_32_2_1;
  import mux_pkg::*;

  localparam int W = 32;
`ifdef MUX_32_2_1_STATS_EN
  localparam int TB_CNT_W = 4;
`else
  localparam int TB_CNT_W = CNT_W_DEFAULT;
`endif
  localparam int CNT_MAX = (1 << TB_CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a0, a1;
  logic         s;
  logic [W-1:0] y, y_q;
  logic         s_q;
`ifdef MUX_32_2_1_STATS_EN
  logic [TB_CNT_W-1:0] tog_cnt;
`endif

  always #5 clk = ~clk;

  mux_32_2_1 #(
    .WIDTH (W),
    .CNT_W (TB_CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a0      (a0),
    .a1      (a1),
    .s       (s),
    .y       (y),
`ifdef MUX_32_2_1_STATS_EN
    .tog_cnt (tog_cnt),
`endif
    .y_q     (y_q),
    .s_q     (s_q)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Tracks what the registered outputs should hold after each edge.
  logic [W-1:0] m_y_q;
  logic         m_s_q;
  int           m_cnt;

  // Selected word: a0 when s is 0, a1 when s is 1, built from masks.
  function automatic logic [W-1:0] model_y(input logic [W-1:0] x0,
                                           input logic [W-1:0] x1,
                                           input logic sv);
    logic [W-1:0] m;
    m = sv ? {W{1'b1}} : {W{1'b0}};
    return (x0 & ~m) | (x1 & m);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [W-1:0] x0, input logic [W-1:0] x1,
                       input logic sv, input logic rv);
    @(negedge clk);
    a0  = x0;
    a1  = x1;
    s   = sv;
    rst = rv;
    #1;
  endtask

  // Advance one rising edge, update the model, settle before sampling.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_y_q = '0;
      m_s_q = 1'b0;
      m_cnt = 0;
    end else begin
      if (s !== m_s_q && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      m_y_q = model_y(a0, a1, s);
      m_s_q = s;
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive('0, '0, SEL_A0, 1'b1);
    tick();
    tick();
    checks++;
    if (y_q !== '0) begin
      errors++; $display("FAIL reset_y_q: got %h expected 0", y_q);
    end
    checks++;
    if (s_q !== 1'b0) begin
      errors++; $display("FAIL reset_s_q: got %b expected 0", s_q);
    end
`ifdef MUX_32_2_1_STATS_EN
    checks++;
    if (tog_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt: got %0d expected 0", tog_cnt);
    end
`endif
  endtask

  // Post-edge check of registered outputs against the model, written out
  // inline in each scenario loop below.
  task automatic test_basic_select();
    drive(32'h0, 32'h1, SEL_A0, 1'b0);
    checks++;
    if (y !== 32'h0) begin
      errors++; $display("FAIL basic_y_s0: got %h expected 0", y);
    end
    repeat (10) tick();  // 100 ns with s = 0
    checks++;
    if (y_q !== 32'h0) begin
      errors++; $display("FAIL basic_y_q_s0: got %h expected 0", y_q);
    end
    drive(32'h0, 32'h1, SEL_A1, 1'b0);
    checks++;
    if (y !== 32'h1) begin
      errors++; $display("FAIL basic_y_s1: got %h expected 1", y);
    end
    checks++;
    if (y_q !== 32'h0) begin
      errors++; $display("FAIL basic_y_q_before_edge: got %h expected 0", y_q);
    end
    tick();
    checks++;
    if (y_q !== 32'h1 || s_q !== 1'b1) begin
      errors++; $display("FAIL basic_y_q_after_edge: got %h/%b expected 1/1", y_q, s_q);
    end
  endtask

  task automatic test_alternate();
    logic [W-1:0] prev_y;
    logic         sv;
    sv = SEL_A0;
    for (int i = 0; i < 12; i++) begin
      drive(32'hDEADBEEF, 32'h12345678, sv, 1'b0);
      checks++;
      if (y !== model_y(32'hDEADBEEF, 32'h12345678, sv)) begin
        errors++; $display("FAIL alt_y[%0d]: got %h expected %h", i, y,
                           model_y(32'hDEADBEEF, 32'h12345678, sv));
      end
      prev_y = model_y(32'hDEADBEEF, 32'h12345678, sv);
      tick();
      checks++;
      if (y_q !== prev_y || s_q !== sv) begin
        errors++; $display("FAIL alt_reg[%0d]: got %h/%b expected %h/%b", i, y_q, s_q, prev_y, sv);
      end
      sv = ~sv;
    end
  endtask

  task automatic test_reset_hold();
    // Load nonzero registered state first.
    drive(32'h0, 32'hFFFFFFFF, SEL_A1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(32'h0, 32'hFFFFFFFF, SEL_A1, 1'b1);
      checks++;
      if (y !== 32'hFFFFFFFF) begin
        errors++; $display("FAIL rsthold_y[%0d]: got %h expected ffffffff", i, y);
      end
      tick();
      checks++;
      if (y_q !== '0 || s_q !== 1'b0) begin
        errors++; $display("FAIL rsthold_reg[%0d]: got %h/%b expected 0/0", i, y_q, s_q);
      end
    end
    drive(32'h0, 32'hFFFFFFFF, SEL_A1, 1'b0);
    tick();
    checks++;
    if (y_q !== 32'hFFFFFFFF || s_q !== 1'b1) begin
      errors++; $display("FAIL rsthold_release: got %h/%b expected ffffffff/1", y_q, s_q);
    end
  endtask

  task automatic test_equal_inputs();
    for (int i = 0; i < 8; i++) begin
      drive(32'hA5A5A5A5, 32'hA5A5A5A5, logic'(i[0]), 1'b0);
      checks++;
      if (y !== 32'hA5A5A5A5) begin
        errors++; $display("FAIL equal_y[%0d]: got %h expected a5a5a5a5", i, y);
      end
      tick();
`ifdef MUX_32_2_1_STATS_EN
      checks++;
      if (int'(tog_cnt) !== m_cnt) begin
        errors++; $display("FAIL equal_cnt[%0d]: got %0d expected %0d", i, tog_cnt, m_cnt);
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x0, x1;
    logic         sv, rv;
    for (int i = 0; i < 60; i++) begin
      x0 = $urandom;
      x1 = $urandom;
      sv = logic'($urandom_range(0, 1));
      rv = ($urandom_range(0, 7) == 0);
      drive(x0, x1, sv, rv);
      checks++;
      if (y !== model_y(x0, x1, sv)) begin
        errors++; $display("FAIL rand_y[%0d]: got %h expected %h", i, y, model_y(x0, x1, sv));
      end
      tick();
      checks++;
      if (y_q !== m_y_q || s_q !== m_s_q) begin
        errors++; $display("FAIL rand_reg[%0d]: got %h/%b expected %h/%b", i, y_q, s_q, m_y_q, m_s_q);
      end
`ifdef MUX_32_2_1_STATS_EN
      checks++;
      if (int'(tog_cnt) !== m_cnt) begin
        errors++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, tog_cnt, m_cnt);
      end
`endif
    end
  endtask

`ifdef MUX_32_2_1_STATS_EN
  task automatic test_counter_saturate();
    drive('0, '0, SEL_A0, 1'b1);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive('0, '1, logic'((i + 1) % 2), 1'b0);
      tick();
      checks++;
      if (int'(tog_cnt) !== m_cnt) begin
        errors++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, tog_cnt, m_cnt);
      end
    end
    checks++;
    if (int'(tog_cnt) !== 15) begin
      errors++; $display("FAIL sat_final: got %0d expected 15", tog_cnt);
    end
  endtask

  task automatic test_reset_with_toggle();
    drive('0, '0, SEL_A0, 1'b0);
    tick();
    drive('0, '0, SEL_A1, 1'b1);  // select change on a reset edge
    tick();
    checks++;
    if (tog_cnt !== '0 || s_q !== 1'b0) begin
      errors++; $display("FAIL rst_tog: got cnt %0d s_q %b expected 0/0", tog_cnt, s_q);
    end
    drive('0, '0, SEL_A1, 1'b0);  // first edge after reset, s=1 vs s_q=0
    tick();
    checks++;
    if (int'(tog_cnt) !== 1) begin
      errors++; $display("FAIL rst_first_edge: got %0d expected 1", tog_cnt);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    a0  = '0;
    a1  = '0;
    s   = SEL_A0;
    m_y_q = '0;
    m_s_q = 1'b0;
    m_cnt = 0;

    test_reset();
    test_basic_select();
    test_alternate();
    test_reset_hold();
    test_equal_inputs();
    test_random();
`ifdef MUX_32_2_1_STATS_EN
    test_counter_saturate();
    test_reset_with_toggle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux_32_2_1
